vc_arb_resp_router: RTL and testbench

VC_ARB_RESP_ROUTER -- requirements
Module: vc_arb_resp_router

---
 rtl/vc_arb_resp_router_pkg.sv | 24 ++
 rtl/vc_arb_resp_router_if.sv | 31 +++
 rtl/vc_arb_id_fifo.sv | 50 +++++
 rtl/vc_arb_resp_router.sv | 75 +++++++
 tb/tb_vc_arb_resp_router.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_arb_resp_router_pkg.sv
// Shared helpers for the arbiter response router: grant encoding and width derivations.
package vc_arb_pkg;

  localparam int MAX_REQS = 16;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Scans from the top down so the lowest set bit wins on a malformed grant vector.
  function automatic logic [3:0] onehot_enc(input logic [MAX_REQS-1:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_REQS - 1; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vc_arb_resp_router_if.sv
// Request/response handshake bundle between the arbiter side and the router.
// err exists only when VC_ARB_RESP_ROUTER_ERR_EN is defined.
interface vc_arb_resp_router_if #(
  parameter int p_num_reqs = 2,
  parameter int p_depth    = 4
);
  localparam int CNT_W = vc_arb_pkg::cnt_w(p_depth);

  logic [p_num_reqs-1:0] grants;
  logic                  req_fire;
  logic                  alloc_rdy;
  logic                  resp_val;
  logic                  resp_rdy;
  logic [p_num_reqs-1:0] out_val;
  logic [p_num_reqs-1:0] out_rdy;
  logic [CNT_W-1:0]      count;
`ifdef VC_ARB_RESP_ROUTER_ERR_EN
  logic                  err;

  modport slave  (input grants, req_fire, resp_val, out_rdy,
                  output alloc_rdy, resp_rdy, out_val, count, err);
  modport master (output grants, req_fire, resp_val, out_rdy,
                  input alloc_rdy, resp_rdy, out_val, count, err);
`else
  modport slave  (input grants, req_fire, resp_val, out_rdy,
                  output alloc_rdy, resp_rdy, out_val, count);
  modport master (output grants, req_fire, resp_val, out_rdy,
                  input alloc_rdy, resp_rdy, out_val, count);
`endif

endinterface

// File: rtl/vc_arb_id_fifo.sv
// In-order ID store: register file with wrapping head/tail pointers and an occupancy count.
// No bypass path, so a pushed ID is visible at the head one cycle later at the earliest.
module vc_arb_id_fifo #(
  parameter int p_depth = 4,
  parameter int p_id_w  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [p_id_w-1:0]        push_id,
  input  logic                     pop,
  output logic [p_id_w-1:0]        head_id,
  output logic [$clog2(p_depth):0] count
);

  localparam int PTR_W = $clog2(p_depth);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(p_depth);

  logic [p_id_w-1:0] mem [p_depth];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign head_id = mem[head];

  // Pointers are exactly PTR_W bits, so increment wraps modulo the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_id;
  end

endmodule

// File: rtl/vc_arb_resp_router.sv
// Records each accepted grant's requester index and steers in-order responses back to it.
// Define VC_ARB_RESP_ROUTER_ERR_EN to add the sticky protocol-error flag.
module vc_arb_resp_router
  import vc_arb_pkg::*;
#(
  parameter int p_num_reqs = 2,
  parameter int p_depth    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  vc_arb_resp_router_if.slave  bus
);

  localparam int IDX_W = idx_w(p_num_reqs);
  localparam int CNT_W = cnt_w(p_depth);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(p_depth);

  logic [3:0]       enc;
  logic [IDX_W-1:0] grant_id;
  logic [IDX_W-1:0] head_id;
  logic [CNT_W-1:0] count;
  logic             grant_any;
  logic             nonempty;
  logic             push;
  logic             pop;

  assign enc       = onehot_enc(MAX_REQS'(bus.grants));
  assign grant_id  = enc[IDX_W-1:0];
  assign grant_any = |bus.grants;
  assign nonempty  = (count != '0);

  assign bus.alloc_rdy = (count != FULL_CNT);
  assign bus.resp_rdy  = nonempty && bus.out_rdy[head_id];
  assign bus.count     = count;

  assign push = bus.req_fire && grant_any && bus.alloc_rdy;
  assign pop  = bus.resp_val && bus.resp_rdy;

  always_comb begin
    bus.out_val = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      bus.out_val[i] = bus.resp_val && nonempty && (head_id == IDX_W'(i));
    end
  end

  vc_arb_id_fifo #(
    .p_depth (p_depth),
    .p_id_w  (IDX_W)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (grant_id),
    .pop     (pop),
    .head_id (head_id),
    .count   (count)
  );

`ifdef VC_ARB_RESP_ROUTER_ERR_EN
  logic err_flag;
  logic spurious;
  logic overflow;

  assign spurious = bus.resp_val && !nonempty;
  assign overflow = bus.req_fire && grant_any && !bus.alloc_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    err_flag <= 1'b0;
    else if (spurious || overflow) err_flag <= 1'b1;
  end

  assign bus.err = err_flag;
`endif

endmodule

// File: tb/tb_vc_arb_resp_router.sv
// Bench for vc_arb_resp_router at p_num_reqs=4, p_depth=4: vector table, corner sequences, random vs queue model.
module tb_vc_arb_resp_router;

  localparam int NR = 4;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vc_arb_resp_router_if #(.p_num_reqs(NR), .p_depth(DP)) bus();

  vc_arb_resp_router #(.p_num_reqs(NR), .p_depth(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0] g;
    logic       f;
    logic       rv;
    logic [3:0] r;
    logic [3:0] e_out;
    logic       e_rdy;
    logic       e_alloc;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl[16];
  int   checks = 0;
  int   errors = 0;
  int   q[$];
  logic m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] g, input logic f, input logic rv, input logic [3:0] r);
    bus.grants   = g;
    bus.req_fire = f;
    bus.resp_val = rv;
    bus.out_rdy  = r;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(4'b0000, 1'b0, 1'b0, 4'b1111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    m_err = 1'b0;
  endtask

  function automatic int lowest(input logic [3:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return 0;
  endfunction

  // Behavioural reference: a queue of requester indices in acceptance order.
  task automatic model_step(input string tag);
    logic [3:0] e_out;
    logic       e_rdy;
    logic       do_pop;
    logic       do_push;
    e_out = '0;
    e_rdy = 1'b0;
    if (q.size() > 0) begin
      e_rdy = bus.out_rdy[q[0]];
      if (bus.resp_val) e_out[q[0]] = 1'b1;
    end
    chk({tag, "_out_val"},   bus.out_val,   e_out);
    chk({tag, "_resp_rdy"},  bus.resp_rdy,  e_rdy);
    chk({tag, "_alloc_rdy"}, bus.alloc_rdy, q.size() != DP);
    chk({tag, "_count"},     bus.count,     q.size());
`ifdef VC_ARB_RESP_ROUTER_ERR_EN
    chk({tag, "_err"}, bus.err, m_err);
`endif
    do_pop  = bus.resp_val && e_rdy;
    do_push = bus.req_fire && (bus.grants != 0) && (q.size() < DP);
    if (bus.resp_val && q.size() == 0) m_err = 1'b1;
    if (bus.req_fire && (bus.grants != 0) && q.size() == DP) m_err = 1'b1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(lowest(bus.grants));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{4'b0010, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 3'd0};
    tbl[1]  = '{4'b1000, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 3'd1};
    tbl[2]  = '{4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0010, 1'b1, 1'b1, 3'd2};
    tbl[3]  = '{4'b0000, 1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 1'b1, 3'd1};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 3'd0};
    tbl[5]  = '{4'b0001, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 3'd0};
    tbl[6]  = '{4'b0110, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 3'd1};
    tbl[7]  = '{4'b0100, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 3'd2};
    tbl[8]  = '{4'b1000, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 3'd3};
    tbl[9]  = '{4'b0010, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 3'd4};
    tbl[10] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0, 3'd4};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 3'd3};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0010, 1'b1, 1'b1, 3'd3};
    tbl[13] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0100, 1'b1, 1'b1, 3'd2};
    tbl[14] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 1'b1, 3'd1};
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 3'd0};

    // Values held during reset, with resp_val high to show it is ignored.
    drive(4'b0000, 1'b0, 1'b1, 4'b1111);
    #2;
    chk("rst_alloc_rdy", bus.alloc_rdy, 1'b1);
    chk("rst_resp_rdy",  bus.resp_rdy,  1'b0);
    chk("rst_out_val",   bus.out_val,   4'b0000);
    chk("rst_count",     bus.count,     3'd0);
`ifdef VC_ARB_RESP_ROUTER_ERR_EN
    chk("rst_err",       bus.err,       1'b0);
`endif
    @(negedge clk);
    drive(4'b0000, 1'b0, 1'b0, 4'b1111);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].g, tbl[i].f, tbl[i].rv, tbl[i].r);
      #1;
      chk($sformatf("tbl%0d_out_val", i),   bus.out_val,   tbl[i].e_out);
      chk($sformatf("tbl%0d_resp_rdy", i),  bus.resp_rdy,  tbl[i].e_rdy);
      chk($sformatf("tbl%0d_alloc_rdy", i), bus.alloc_rdy, tbl[i].e_alloc);
      chk($sformatf("tbl%0d_count", i),     bus.count,     tbl[i].e_cnt);
      tick();
    end
`ifdef VC_ARB_RESP_ROUTER_ERR_EN
    chk("tbl_overflow_err", bus.err, 1'b1);
`endif

    // Concurrent push/pop at count=2 across pointer wrap.
    do_reset();
    drive(4'b0001, 1'b1, 1'b0, 4'b1111); #1; tick();
    drive(4'b0010, 1'b1, 1'b0, 4'b1111); #1; tick();
    for (int k = 0; k < 6; k++) begin
      logic [3:0] g;
      logic [3:0] e;
      g = '0; g[(k + 2) % 4] = 1'b1;
      e = '0; e[k % 4] = 1'b1;
      drive(g, 1'b1, 1'b1, 4'b1111);
      #1;
      chk($sformatf("pp%0d_out_val", k), bus.out_val, e);
      chk($sformatf("pp%0d_count", k),   bus.count,   3'd2);
      chk($sformatf("pp%0d_resp_rdy", k), bus.resp_rdy, 1'b1);
      tick();
    end
    drive(4'b0000, 1'b0, 1'b1, 4'b1111); #1;
    chk("pp_drain0_out_val", bus.out_val, 4'b0100); tick();
    drive(4'b0000, 1'b0, 1'b1, 4'b1111); #1;
    chk("pp_drain1_out_val", bus.out_val, 4'b1000); tick();
    drive(4'b0000, 1'b0, 1'b0, 4'b1111); #1;
    chk("pp_drain_count", bus.count, 3'd0);

    // Backpressure from the head requester only.
    do_reset();
    drive(4'b1000, 1'b1, 1'b0, 4'b1111); #1; tick();
    drive(4'b0000, 1'b0, 1'b1, 4'b0111); #1;
    chk("bp0_resp_rdy", bus.resp_rdy, 1'b0);
    chk("bp0_out_val",  bus.out_val,  4'b1000);
    tick(); #1;
    chk("bp1_out_val", bus.out_val, 4'b1000);
    chk("bp1_count",   bus.count,   3'd1);
    drive(4'b0000, 1'b0, 1'b1, 4'b1111); #1;
    chk("bp2_resp_rdy", bus.resp_rdy, 1'b1);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 4'b1111); #1;
    chk("bp3_count", bus.count, 3'd0);

    // Spurious response while empty.
    do_reset();
    drive(4'b0000, 1'b0, 1'b1, 4'b1111); #1;
    chk("sp_resp_rdy", bus.resp_rdy, 1'b0);
    chk("sp_out_val",  bus.out_val,  4'b0000);
`ifdef VC_ARB_RESP_ROUTER_ERR_EN
    chk("sp_err_before", bus.err, 1'b0);
`endif
    tick();
    drive(4'b0000, 1'b0, 1'b0, 4'b1111); #1;
    chk("sp_count", bus.count, 3'd0);
`ifdef VC_ARB_RESP_ROUTER_ERR_EN
    chk("sp_err_set", bus.err, 1'b1);
    tick(); #1;
    chk("sp_err_sticky", bus.err, 1'b1);
`endif

    // Asynchronous reset in the middle of a clock phase with three IDs outstanding.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0100, 1'b1, 1'b0, 4'b1111); #1; tick();
    end
    drive(4'b0000, 1'b0, 1'b0, 4'b1111); #1;
    chk("ar_count_before", bus.count, 3'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_count_now", bus.count,     3'd0);
    chk("ar_alloc_now", bus.alloc_rdy, 1'b1);
    chk("ar_rdy_now",   bus.resp_rdy,  1'b0);
    tick();
    reset = 1'b0;
    drive(4'b0000, 1'b0, 1'b1, 4'b1111); #1;
    chk("ar_resp_out_val", bus.out_val,  4'b0000);
    chk("ar_resp_rdy",     bus.resp_rdy, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 4'b1111); #1;
    chk("ar_count_after", bus.count, 3'd0);

    // Randomised traffic against the queue model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] g;
      int mode;
      mode = $urandom_range(0, 3);
      g = '0;
      if (mode == 1 || mode == 2) g[$urandom_range(0, 3)] = 1'b1;
      else if (mode == 3) g = 4'($urandom);
      drive(g, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            4'($urandom) | 4'($urandom));
      #1;
      model_step($sformatf("rnd%0d", n));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
